seq_game_ctrl: RTL and testbench

Parametrised control unit for the memory-sequence game. It replaces the fixed 4-item controller with a configurable one: round count, per-item display time and a timeout with a difficulty selector are all set by parameters. It sits between the debounced board keys and the game datapath. It sequences the display of the stored pattern, collects and checks the user's entries against a per-round countdown, and reports win or lose.

---
 rtl/seq_game_pkg.sv | 30 +++
 rtl/seq_game_ctrl_if.sv | 33 +++
 rtl/seq_tick_gen.sv | 37 +++
 rtl/seq_game_ctrl.sv | 176 +++++++++++++++++
 tb/tb_seq_game_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_game_pkg.sv
// seq_game_pkg: shared types and helpers for the memory-sequence game controller.
//   state_e         - controller state encoding (binary, 3 bits)
//   ShowEnDec/ClrDec/BusyDec - per-state output decode, one bit per state value
//   timeout_secs()  - answer time for a round given the latched difficulty level
package seq_game_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StShow   = 3'd1,
        StWaitIn = 3'd2,
        StCheck  = 3'd3,
        StNext   = 3'd4,
        StWin    = 3'd5,
        StLose   = 3'd6
    } state_e;

    // Bit n of each mask is the output value while the state encoding equals n.
    localparam logic [7:0] ShowEnDec = 8'b0000_0010;
    localparam logic [7:0] ClrDec    = 8'b0000_0001;
    localparam logic [7:0] BusyDec   = 8'b0001_1110;

    // Each difficulty step halves the answer time; never drop below one second.
    function automatic int unsigned timeout_secs(input int unsigned play_secs,
                                                 input logic [1:0]  level);
        int unsigned t;
        t = play_secs >> level;
        return (t == 0) ? 1 : t;
    endfunction

endpackage

// File: rtl/seq_game_ctrl_if.sv
// seq_game_ctrl_if: key/datapath-facing signal bundle of the game controller.
//   master: the controller (drives sequencing outputs, reads keys and compare result)
//   slave : the board/datapath side
//   enter, level, match             - key confirm pulse, difficulty, datapath compare
//   seq_idx, round, show_en, ld_user,
//   clr, secs_left, busy, win, lose - controller outputs
interface seq_game_ctrl_if #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned SEC_W = 4
);
    logic             enter;
    logic [1:0]       level;
    logic             match;
    logic [IDX_W-1:0] seq_idx;
    logic [IDX_W-1:0] round;
    logic             show_en;
    logic             ld_user;
    logic             clr;
    logic [SEC_W-1:0] secs_left;
    logic             busy;
    logic             win;
    logic             lose;

    modport master (
        input  enter, level, match,
        output seq_idx, round, show_en, ld_user, clr, secs_left, busy, win, lose
    );

    modport slave (
        output enter, level, match,
        input  seq_idx, round, show_en, ld_user, clr, secs_left, busy, win, lose
    );
endinterface

// File: rtl/seq_tick_gen.sv
// seq_tick_gen: one-second prescaler for the answer countdown.
//   i_clk   - system clock
//   i_rst_n - synchronous active-low reset
//   i_clr   - synchronous clear; counter restarts from 0 on the next edge
//   o_tick  - high for one cycle while the counter sits at TICK_DIV-1
module seq_tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);
    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_nxt;
    logic            w_wrap;

    assign w_wrap = (r_cnt == CntW'(TICK_DIV - 1));
    assign o_tick = w_wrap;

    always_comb begin
        w_cnt_nxt = r_cnt + CntW'(1);
        if (i_clr || w_wrap) begin
            w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
endmodule

// File: rtl/seq_game_ctrl.sv
// seq_game_ctrl: control unit for the memory-sequence game.
// Shows the stored pattern item by item, collects the user's entries against a per-round
// countdown, and reports win or lose.
//   CLOCK_50 - system clock
//   reset    - synchronous active-low reset, returns to IDLE
//   bus      - seq_game_ctrl_if.master: enter/level/match in; seq_idx, round, show_en,
//              ld_user, clr, secs_left, busy, win, lose out
module seq_game_ctrl
    import seq_game_pkg::*;
#(
    parameter int unsigned ROUNDS    = 16,
    parameter int unsigned SHOW_CYC  = 25_000_000,
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned PLAY_SECS = 15,
    parameter int unsigned IDX_W     = $clog2(ROUNDS),
    parameter int unsigned SEC_W     = $clog2(PLAY_SECS + 1)
) (
    input logic               CLOCK_50,
    input logic               reset,
    seq_game_ctrl_if.master   bus
);
    localparam int unsigned HoldW = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [HoldW-1:0] r_hold;
    logic [HoldW-1:0] w_hold_nxt;
    logic [IDX_W-1:0] r_seq_idx;
    logic [IDX_W-1:0] w_seq_idx_nxt;
    logic [IDX_W-1:0] r_round;
    logic [IDX_W-1:0] w_round_nxt;
    logic [SEC_W-1:0] r_secs;
    logic [SEC_W-1:0] w_secs_nxt;
    logic [1:0]       r_level;
    logic [1:0]       w_level_nxt;
    logic             r_show_en;
    logic             r_clr;
    logic             r_busy;
    logic             r_win;
    logic             r_lose;

    logic             w_tick;
    logic             w_tick_clr;
    logic [SEC_W-1:0] w_timeout;
    logic             w_last_item;

    seq_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk   (CLOCK_50),
        .i_rst_n (reset),
        .i_clr   (w_tick_clr),
        .o_tick  (w_tick)
    );

    assign w_timeout   = SEC_W'(timeout_secs(PLAY_SECS, r_level));
    assign w_last_item = (r_seq_idx == r_round);

    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold;
        w_seq_idx_nxt = r_seq_idx;
        w_round_nxt   = r_round;
        w_secs_nxt    = r_secs;
        w_level_nxt   = r_level;
        w_tick_clr    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (bus.enter) begin
                    w_level_nxt   = bus.level;
                    w_round_nxt   = '0;
                    w_seq_idx_nxt = '0;
                    w_hold_nxt    = '0;
                    w_state_nxt   = StShow;
                end
            end
            StShow: begin
                if (r_hold == HoldW'(SHOW_CYC - 1)) begin
                    w_hold_nxt = '0;
                    if (w_last_item) begin
                        // Restart the prescaler so the first second is a full TICK_DIV.
                        w_seq_idx_nxt = '0;
                        w_secs_nxt    = w_timeout;
                        w_tick_clr    = 1'b1;
                        w_state_nxt   = StWaitIn;
                    end else begin
                        w_seq_idx_nxt = r_seq_idx + IDX_W'(1);
                    end
                end else begin
                    w_hold_nxt = r_hold + HoldW'(1);
                end
            end
            StWaitIn: begin
                if (w_tick && (r_secs != '0)) begin
                    w_secs_nxt = r_secs - SEC_W'(1);
                end
                // Enter has priority over expiry. A zero count can also be carried back in
                // from CHECK when the last second ran out on the enter cycle.
                if (bus.enter) begin
                    w_state_nxt = StCheck;
                end else if ((r_secs == '0) || (w_tick && (r_secs == SEC_W'(1)))) begin
                    w_state_nxt = StLose;
                end
            end
            StCheck: begin
                if (!bus.match) begin
                    w_state_nxt = StLose;
                end else if (w_last_item) begin
                    w_state_nxt = StNext;
                end else begin
                    w_seq_idx_nxt = r_seq_idx + IDX_W'(1);
                    w_state_nxt   = StWaitIn;
                end
            end
            StNext: begin
                if (r_round == IDX_W'(ROUNDS - 1)) begin
                    w_state_nxt = StWin;
                end else begin
                    w_round_nxt   = r_round + IDX_W'(1);
                    w_seq_idx_nxt = '0;
                    w_hold_nxt    = '0;
                    w_state_nxt   = StShow;
                end
            end
            StWin, StLose: begin
                if (bus.enter) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_hold    <= '0;
            r_seq_idx <= '0;
            r_round   <= '0;
            r_secs    <= '0;
            r_level   <= '0;
            r_show_en <= 1'b0;
            r_clr     <= 1'b1;
            r_busy    <= 1'b0;
            r_win     <= 1'b0;
            r_lose    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hold    <= w_hold_nxt;
            r_seq_idx <= w_seq_idx_nxt;
            r_round   <= w_round_nxt;
            r_secs    <= w_secs_nxt;
            r_level   <= w_level_nxt;
            // Flags are decoded from the next state so they line up with the state register.
            r_show_en <= ShowEnDec[w_state_nxt];
            r_clr     <= ClrDec[w_state_nxt];
            r_busy    <= BusyDec[w_state_nxt];
            r_win     <= (w_state_nxt == StWin);
            r_lose    <= (w_state_nxt == StLose);
        end
    end

    // Combinational so the datapath captures the switches in the enter cycle itself.
    assign bus.ld_user   = (r_state == StWaitIn) && bus.enter;
    assign bus.seq_idx   = r_seq_idx;
    assign bus.round     = r_round;
    assign bus.secs_left = r_secs;
    assign bus.show_en   = r_show_en;
    assign bus.clr       = r_clr;
    assign bus.busy      = r_busy;
    assign bus.win       = r_win;
    assign bus.lose      = r_lose;
endmodule

// File: tb/tb_seq_game_ctrl.sv
// tb_seq_game_ctrl: scoreboard bench for seq_game_ctrl.
// Stimulus pushes cycle-stamped expectations; a negedge monitor compares them as they fall due.
module tb_seq_game_ctrl;
    localparam int unsigned Rounds   = 4;
    localparam int unsigned ShowCyc  = 3;
    localparam int unsigned TickDiv  = 10;
    localparam int unsigned PlaySecs = 8;

    localparam int SelClr   = 0;
    localparam int SelBusy  = 1;
    localparam int SelWin   = 2;
    localparam int SelLose  = 3;
    localparam int SelShow  = 4;
    localparam int SelIdx   = 5;
    localparam int SelRound = 6;
    localparam int SelSecs  = 7;
    localparam int SelLd    = 8;

    typedef struct {
        int unsigned cyc;
        int          sel;
        int unsigned val;
        string       tag;
    } exp_t;

    logic        clk;
    logic        reset;
    int unsigned cyc;
    int          n_tests;
    int          n_fail;
    int          mon_i;
    exp_t        sb[$];

    seq_game_ctrl_if #(.IDX_W(2), .SEC_W(4)) bus ();

    seq_game_ctrl #(
        .ROUNDS    (Rounds),
        .SHOW_CYC  (ShowCyc),
        .TICK_DIV  (TickDiv),
        .PLAY_SECS (PlaySecs)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic int unsigned probe(input int sel);
        case (sel)
            SelClr:   return int'(bus.clr);
            SelBusy:  return int'(bus.busy);
            SelWin:   return int'(bus.win);
            SelLose:  return int'(bus.lose);
            SelShow:  return int'(bus.show_en);
            SelIdx:   return int'(bus.seq_idx);
            SelRound: return int'(bus.round);
            SelSecs:  return int'(bus.secs_left);
            SelLd:    return int'(bus.ld_user);
            default:  return 32'hdead;
        endcase
    endfunction

    // Monitor: compare every expectation stamped with the current cycle.
    initial begin
        n_tests = 0;
        n_fail  = 0;
        forever begin
            @(negedge clk);
            mon_i = 0;
            while (mon_i < sb.size()) begin
                if (sb[mon_i].cyc == cyc) begin
                    n_tests++;
                    if (probe(sb[mon_i].sel) !== sb[mon_i].val) begin
                        n_fail++;
                        $display("FAIL %s @cyc %0d: got %0d, expected %0d", sb[mon_i].tag, cyc,
                                 probe(sb[mon_i].sel), sb[mon_i].val);
                    end
                    sb.delete(mon_i);
                end else if (sb[mon_i].cyc < cyc) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s: expectation for cyc %0d never sampled (now %0d)",
                             sb[mon_i].tag, sb[mon_i].cyc, cyc);
                    sb.delete(mon_i);
                end else begin
                    mon_i++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int unsigned c, input int sel, input int unsigned v,
                             input string tag);
        exp_t e;
        e.cyc = c;
        e.sel = sel;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic exp_now(input int sel, input int unsigned v, input string tag);
        expect_at(cyc, sel, v, tag);
    endtask

    // IDLE -> SHOW; returns in the first SHOW cycle.
    task automatic do_start(input logic [1:0] lv);
        bus.level = lv;
        bus.enter = 1'b1;
        tick(1);
        bus.enter = 1'b0;
        bus.level = 2'd0;
    endtask

    // Round r shows r+1 items of ShowCyc cycles; returns in the first WAIT_IN cycle.
    task automatic wait_show(input int unsigned r, input int unsigned secs);
        int unsigned a;
        a = cyc;
        expect_at(a, SelRound, r, "show_round");
        expect_at(a, SelShow, 1, "show_first");
        expect_at(a + ShowCyc * r, SelIdx, r, "show_last_idx");
        expect_at(a + ShowCyc * (r + 1) - 1, SelShow, 1, "show_last_cyc");
        expect_at(a + ShowCyc * (r + 1), SelShow, 0, "show_end");
        expect_at(a + ShowCyc * (r + 1), SelSecs, secs, "secs_load");
        tick(ShowCyc * (r + 1));
    endtask

    // Correct entries back to back; returns two cycles after the last enter.
    task automatic answer(input int n);
        for (int k = 0; k < n; k++) begin
            bus.match = 1'b1;
            bus.enter = 1'b1;
            exp_now(SelLd, 1, "ld_user_enter");
            tick(1);
            bus.enter = 1'b0;
            exp_now(SelLd, 0, "ld_user_check");
            tick(1);
            if (k < n - 1) exp_now(SelIdx, k + 1, "idx_step");
        end
    endtask

    // WIN/LOSE -> IDLE.
    task automatic leave_end();
        exp_now(SelClr, 0, "clr_before_exit");
        bus.enter = 1'b1;
        tick(1);
        bus.enter = 1'b0;
        exp_now(SelClr, 1, "clr_exit");
        exp_now(SelWin, 0, "win_exit");
        exp_now(SelLose, 0, "lose_exit");
        exp_now(SelBusy, 0, "busy_idle");
    endtask

    initial begin
        int unsigned w;
        reset     = 1'b0;
        bus.enter = 1'b0;
        bus.level = 2'd0;
        bus.match = 1'b0;
        tick(2);
        exp_now(SelClr, 1, "rst_clr");
        exp_now(SelBusy, 0, "rst_busy");
        exp_now(SelWin, 0, "rst_win");
        exp_now(SelLose, 0, "rst_lose");
        exp_now(SelShow, 0, "rst_show");
        exp_now(SelIdx, 0, "rst_idx");
        exp_now(SelRound, 0, "rst_round");
        exp_now(SelSecs, 0, "rst_secs");
        reset = 1'b1;
        tick(1);
        exp_now(SelClr, 1, "idle_clr");

        // Full win over four rounds
        do_start(2'd0);
        exp_now(SelBusy, 1, "start_busy");
        exp_now(SelClr, 0, "start_clr");
        exp_now(SelIdx, 0, "start_idx");
        for (int r = 0; r < Rounds; r++) begin
            wait_show(r, 8);
            answer(r + 1);
            tick(1);
        end
        exp_now(SelWin, 1, "win_flag");
        exp_now(SelBusy, 0, "win_busy");
        exp_now(SelLose, 0, "win_lose");
        exp_now(SelRound, 3, "win_round");
        tick(2);
        exp_now(SelWin, 1, "win_hold");
        exp_now(SelIdx, 3, "win_idx_frozen");
        leave_end();

        // Wrong entry on second item of round 1
        do_start(2'd0);
        wait_show(0, 8);
        answer(1);
        tick(1);
        wait_show(1, 8);
        answer(1);
        bus.match = 1'b0;
        bus.enter = 1'b1;
        exp_now(SelLd, 1, "wrong_ld_user");
        tick(1);
        bus.enter = 1'b0;
        exp_now(SelLose, 0, "wrong_check");
        tick(1);
        exp_now(SelLose, 1, "wrong_lose");
        exp_now(SelBusy, 0, "wrong_busy");
        exp_now(SelRound, 1, "wrong_round");
        exp_now(SelIdx, 1, "wrong_idx");
        tick(2);
        exp_now(SelLose, 1, "wrong_lose_hold");
        bus.match = 1'b1;
        leave_end();

        // Timeout at level 2: 8>>2 = 2 seconds
        do_start(2'd2);
        wait_show(0, 2);
        w = cyc;
        expect_at(w + 9, SelSecs, 2, "to2_secs_pre_tick");
        expect_at(w + 10, SelSecs, 1, "to2_secs_dec");
        expect_at(w + 19, SelLose, 0, "to2_not_yet");
        expect_at(w + 20, SelLose, 1, "to2_lose");
        expect_at(w + 20, SelSecs, 0, "to2_secs_zero");
        tick(21);
        leave_end();

        // Level 3: load is 1
        do_start(2'd3);
        wait_show(0, 1);
        w = cyc;
        expect_at(w + 9, SelLose, 0, "to3_not_yet");
        expect_at(w + 10, SelLose, 1, "to3_lose");
        tick(11);
        leave_end();

        // Enter in the same cycle the last second expires
        do_start(2'd3);
        wait_show(0, 1);
        tick(9);
        exp_now(SelSecs, 1, "sim_secs_pre");
        bus.match = 1'b1;
        bus.enter = 1'b1;
        exp_now(SelLd, 1, "sim_ld_user");
        tick(1);
        bus.enter = 1'b0;
        exp_now(SelLose, 0, "sim_check_not_lose");
        exp_now(SelBusy, 1, "sim_check_busy");
        exp_now(SelSecs, 0, "sim_secs_zero");
        tick(1);
        exp_now(SelLose, 0, "sim_next");
        tick(1);
        wait_show(1, 1);
        answer(2);
        tick(1);

        // Reset in round 2 while item 1 is on display
        exp_now(SelRound, 2, "mid_round2");
        tick(4);
        exp_now(SelIdx, 1, "mid_idx1");
        exp_now(SelShow, 1, "mid_show");
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        exp_now(SelClr, 1, "mid_rst_clr");
        exp_now(SelRound, 0, "mid_rst_round");
        exp_now(SelIdx, 0, "mid_rst_idx");
        exp_now(SelShow, 0, "mid_rst_show");
        exp_now(SelBusy, 0, "mid_rst_busy");
        exp_now(SelSecs, 0, "mid_rst_secs");
        tick(3);
        exp_now(SelClr, 1, "mid_idle_stays");
        exp_now(SelBusy, 0, "mid_idle_busy");
        tick(2);

        while (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: never sampled, got none, expected %0d", sb[0].tag, sb[0].val);
            sb.delete(0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
